// File: rtl/clk_pkg.sv
// Shared types and default timing constants for the clock's mode/set control and display mux.
package clk_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } ctrl_mode_t;

    localparam int REPEAT_DLY_DEF  = 500;
    localparam int REPEAT_RATE_DEF = 200;
    localparam int BLINK_HALF_DEF  = 250;
    localparam int TIMEOUT_DEF     = 10000;
    localparam int CW_DEF          = 16;

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold-to-auto-repeat for one debounced button.
// o_pulse is combinational; the parent registers it.
module btn_repeat #(
    parameter int DLY  = 4,
    parameter int RATE = 3,
    parameter int CW   = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_edge,
    output logic o_pulse
);

    logic          r_prev;
    logic          r_active;
    logic          r_rate;
    logic [CW-1:0] r_cnt;
    logic          w_fire;

    assign o_edge  = i_btn & ~r_prev;
    assign w_fire  = r_active & i_btn & (r_cnt == (r_rate ? CW'(RATE) : CW'(DLY)));
    assign o_pulse = i_en & ~i_clr & (o_edge | w_fire);

    // r_active only arms from an edge seen while enabled and not cleared,
    // so a hold carried across a mode change never repeats.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev   <= 1'b0;
            r_active <= 1'b0;
            r_rate   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_prev <= i_btn;
            if (!i_en || i_clr || !i_btn) begin
                r_active <= 1'b0;
                r_rate   <= 1'b0;
                r_cnt    <= '0;
            end else if (o_edge) begin
                r_active <= 1'b1;
                r_rate   <= 1'b0;
                r_cnt    <= CW'(1);
            end else if (w_fire) begin
                r_rate <= 1'b1;
                r_cnt  <= CW'(1);
            end else if (r_active && r_cnt != '1) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/set controller: freezes time counters while setting, issues hour/minute
// increment pulses with auto-repeat, owns the 12/24h flag and edit-field blinking.
module time_set_ctrl
    import clk_pkg::*;
#(
    parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
    parameter int REPEAT_RATE = REPEAT_RATE_DEF,
    parameter int BLINK_HALF  = BLINK_HALF_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int CW          = CW_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic       i_btn_fmt,
    output logic       o_run_en,
    output logic       o_f_inc_hr,
    output logic       o_f_inc_min,
    output logic       o_clr_sec,
    output logic       o_mil_time,
    output logic       o_blank_hr,
    output logic       o_blank_min,
    output logic [1:0] o_mode
);

    ctrl_mode_t    r_state, w_next;
    logic          r_mode_prev, r_fmt_prev;
    logic          r_run_en, r_f_inc_hr, r_f_inc_min, r_clr_sec, r_mil_time;
    logic          r_blank_hr, r_blank_min, r_phase;
    logic [CW-1:0] r_idle, r_blink;
    logic [CW-1:0] w_idle_nxt, w_blink_nxt;
    logic          w_phase_nxt;
    logic          w_mode_edge, w_fmt_edge, w_inc_edge, w_inc_pulse;
    logic          w_mode_chg, w_timeout;

    assign w_mode_edge = i_btn_mode & ~r_mode_prev;
    assign w_fmt_edge  = i_btn_fmt & ~r_fmt_prev;
    assign w_timeout   = (r_state != RUN) && (r_idle == CW'(TIMEOUT - 1));
    assign w_mode_chg  = (w_next != r_state);

    btn_repeat #(
        .DLY  (REPEAT_DLY),
        .RATE (REPEAT_RATE),
        .CW   (CW)
    ) u_inc_rep (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_inc),
        .i_en    (r_state != RUN),
        .i_clr   (w_mode_chg),
        .o_edge  (w_inc_edge),
        .o_pulse (w_inc_pulse)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:     if (w_mode_edge) w_next = SET_HR;
            SET_HR:  if (w_mode_edge) w_next = SET_MIN;
                     else if (w_timeout) w_next = RUN;
            SET_MIN: if (w_mode_edge || w_timeout) w_next = RUN;
            default: w_next = RUN;
        endcase
    end

    // Idle and blink timers restart on every state change and sit at 0 in RUN.
    always_comb begin
        w_idle_nxt  = r_idle;
        w_blink_nxt = r_blink;
        w_phase_nxt = r_phase;
        if (w_next == RUN || w_mode_chg) begin
            w_idle_nxt  = '0;
            w_blink_nxt = '0;
            w_phase_nxt = 1'b0;
        end else begin
            if (w_mode_edge || w_inc_edge || w_fmt_edge || w_inc_pulse)
                w_idle_nxt = '0;
            else if (r_idle != '1)
                w_idle_nxt = r_idle + CW'(1);
            if (r_blink == CW'(BLINK_HALF - 1)) begin
                w_blink_nxt = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_blink_nxt = r_blink + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= RUN;
            r_mode_prev <= 1'b0;
            r_fmt_prev  <= 1'b0;
            r_run_en    <= 1'b1;
            r_mil_time  <= 1'b1;
            r_f_inc_hr  <= 1'b0;
            r_f_inc_min <= 1'b0;
            r_clr_sec   <= 1'b0;
            r_blank_hr  <= 1'b0;
            r_blank_min <= 1'b0;
            r_idle      <= '0;
            r_blink     <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_mode_prev <= i_btn_mode;
            r_fmt_prev  <= i_btn_fmt;
            r_run_en    <= (w_next == RUN);
            r_mil_time  <= r_mil_time ^ w_fmt_edge;
            r_f_inc_hr  <= w_inc_pulse && (r_state == SET_HR);
            r_f_inc_min <= w_inc_pulse && (r_state == SET_MIN);
            r_clr_sec   <= (r_state == SET_MIN) && (w_next == RUN);
            r_blank_hr  <= (w_next == SET_HR) && w_phase_nxt;
            r_blank_min <= (w_next == SET_MIN) && w_phase_nxt;
            r_idle      <= w_idle_nxt;
            r_blink     <= w_blink_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    assign o_run_en    = r_run_en;
    assign o_f_inc_hr  = r_f_inc_hr;
    assign o_f_inc_min = r_f_inc_min;
    assign o_clr_sec   = r_clr_sec;
    assign o_mil_time  = r_mil_time;
    assign o_blank_hr  = r_blank_hr;
    assign o_blank_min = r_blank_min;
    assign o_mode      = r_state;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Mode/set controller that sequences the clock's time counters (sec/min/hr) and display formatting from three front-panel buttons. It freezes the running counters while the user sets time and issues single-cycle increment pulses to the hour and minute counters, with hold-to-auto-repeat. It also clears seconds on exit from set mode, owns the 12/24-hour format flag and drives blanking for the field being edited. It sits between the debounced button block and the sec/min/hr counter chain, all in one clock domain.

Parameters:
REPEAT_DLY, 500, cycles btn_inc must stay held after its rising edge before auto-repeat starts (min 2)
REPEAT_RATE, 200, cycles between auto-repeat pulses (min 2)
BLINK_HALF, 250, cycles per blink half-period in set states (min 1)
TIMEOUT, 10000, idle cycles in a set state before automatic return to RUN (min 4)
CW, 16, width of internal timing counters; must hold the largest of the above

Ports:
clk  in  1  system clock (single domain; all buttons already synchronized to it)
reset  in  1  synchronous, active-high reset
btn_mode  in  1  debounced level; rising edge advances mode
btn_inc  in  1  debounced level; rising edge or hold increments selected field
btn_fmt  in  1  debounced level; rising edge toggles 12/24-hour format
run_en  out  1  high = time counters advance normally; low = frozen
f_inc_hr  out  1  one-cycle increment pulse to hour counter
f_inc_min  out  1  one-cycle increment pulse to minute counter
clr_sec  out  1  one-cycle pulse clearing seconds counter
mil_time  out  1  1 = 24-hour display, 0 = AM/PM
blank_hr  out  1  high = blank hour digits (blink off-phase)
blank_min  out  1  high = blank minute digits (blink off-phase)
mode  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN

Behaviour:
- Reset (clk edge with reset=1): mode=RUN, run_en=1, mil_time=1, all pulses 0, blank_* 0, all timing counters 0, button history registers 0. This includes reset mid-set and mid-repeat: no pulse is emitted in the cycle after reset deasserts, even if a button is already high.
- Edge detect: each button has a registered previous value. A rising edge is detected in cycle n when the button is 1 and its previous value is 0. Every output is registered, so the response appears in cycle n+1.
- FSM transitions on btn_mode edge: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN. Encoding 2'b11 is unreachable; if entered, go to RUN.
- run_en = (mode==RUN), registered with the state.
- clr_sec: one-cycle pulse in the same cycle mode becomes RUN from SET_MIN, whether by btn_mode or by timeout. Not pulsed on timeout from SET_HR.
- Increment in SET_HR or SET_MIN:
  - btn_inc edge -> one pulse on f_inc_hr or f_inc_min (selected field only) in cycle n+1.
  - Holding btn_inc for REPEAT_DLY cycles after the edge gives further pulses, then one every REPEAT_RATE cycles while it stays held.
  - Release clears the repeat counter.
  - In RUN, btn_inc is ignored and no repeat counting occurs.
- Simultaneous btn_mode and btn_inc edges: mode wins. No inc pulse is emitted and the repeat counter clears. An inc held across a mode change produces no repeat in the new state until a fresh edge.
- btn_fmt edge toggles mil_time in any state, independent of the other buttons and of simultaneous edges.
- Timeout:
  - Idle counter clears on any button edge and on entry to a set state.
  - Auto-repeat pulses also clear it.
  - When it reaches TIMEOUT-1 in a set state, mode->RUN next cycle.
  - It is held at 0 in RUN.
- Blink:
  - Phase counter runs only in set states and wraps at BLINK_HALF-1, toggling a phase bit; phase starts at 0 (on) on entry to a set state.
  - blank_hr = (mode==SET_HR) & phase; blank_min = (mode==SET_MIN) & phase.
  - Both are 0 in RUN.
- Counters saturate rather than wrap when they sit at a terminal value.
- No two of f_inc_hr, f_inc_min, clr_sec are ever high in the same cycle.

Decomposition:
- Shared package clk_pkg holds:
  - typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} ctrl_mode_t, also used by the display mux.
  - Default constants for REPEAT_DLY, REPEAT_RATE, BLINK_HALF, TIMEOUT.
- One natural sub-module: btn_repeat, instantiated once for btn_inc. It provides edge detect plus a delay/rate counter and outputs a one-cycle pulse. It has an enable input, and a clear input used on mode change.
- Edge detects for btn_mode and btn_fmt stay inline in time_set_ctrl.

Test Plan:
- Reset then idle 20 cycles -> mode=0, run_en=1, mil_time=1, all pulses 0, blank_* 0.
- Three btn_mode taps (each 1 cycle high, spaced 5 cycles) -> mode 1, 2, 0, each one cycle after its edge. Exactly one clr_sec pulse, coincident with mode=0. run_en low only while mode is 1 or 2.
- SET_HR with REPEAT_DLY=4, REPEAT_RATE=3, btn_inc held 14 cycles -> f_inc_hr pulses at cycles 1, 5, 8, 11, 14 after the edge. f_inc_min stays 0. No pulses after release.
- btn_mode and btn_inc rising in the same cycle while in SET_HR -> mode=2 next cycle. No f_inc_* pulse. Continued hold gives no repeat until inc is released and pressed again.
- SET_MIN with TIMEOUT=8, no buttons -> mode=0 on the 8th idle cycle, with one clr_sec pulse in that cycle. blank_min toggles every BLINK_HALF cycles before that and is 0 after.
- btn_fmt edge in RUN, then in SET_HR, then reset asserted mid-repeat in SET_MIN -> mil_time 1->0->1. Reset returns mode=0, mil_time=1, no f_inc_min pulse after reset deasserts.
